fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue.
//  Sits between instruction memory and decode. Decouples variable-latency memory
//  (valid handshake) from decode stalls. Supports branch redirect (flush) with
//  stale-response discard, halt, and a delivered-instruction counter.
// PARAMETERS
//  WORD_SIZE  16  data/address width; word-addressed, PC increments by 1
//  DEPTH      4   prefetch queue entries; power of 2, >= 2
//  RESET_PC   0   fetch PC after reset
// PORTS
//  clk              in   1          clock, rising edge
//  reset_n          in   1          asynchronous, active-low reset
//  i_readM          out  1          instruction read request, held until i_data_valid
//  i_address        out  WORD_SIZE  request address, stable while i_readM=1
//  i_data           in   WORD_SIZE  read data, sampled when i_data_valid=1
//  i_data_valid     in   1          read response strobe, 1 cycle per request
//  halt             in   1          stop issuing new requests
//  flush            in   1          redirect: discard queue and in-flight data
//  flush_target     in   WORD_SIZE  new fetch PC when flush=1
//  inst_ready       in   1          decode accepts head entry
//  inst_valid       out  1          queue non-empty
//  inst             out  WORD_SIZE  head instruction
//  inst_pc          out  WORD_SIZE  PC of head instruction
//  occupancy        out  $clog2(DEPTH+1)  queue entry count
//  delivered_count  out  WORD_SIZE  number of pops since reset, wraps mod 2^WORD_SIZE
// BEHAVIOUR
//  Reset (async): state=IDLE, fetch_pc=RESET_PC, queue empty, delivered_count=0;
//   all outputs 0 except i_address=RESET_PC.
//  FSM: IDLE, WAIT, DISCARD. i_readM=1 in WAIT and DISCARD; i_address=fetch_pc.
//  One request outstanding max. issue_ok = !halt && (occ_next < DEPTH), where
//   occ_next = occupancy after this cycle's push/pop (one slot reserved per request).
//  IDLE: issue_ok -> WAIT; else stay.
//  WAIT, i_data_valid=1: push {fetch_pc, i_data}; fetch_pc<=fetch_pc+1 (wraps);
//   issue_ok -> stay WAIT (back-to-back, new address next cycle); else -> IDLE.
//  WAIT, no response: hold address and request.
//  DISCARD: hold request; on i_data_valid drop data, -> IDLE. No push.
//  i_data_valid in IDLE ignored.
//  Flush (highest priority, that edge): queue cleared, no push/pop counted,
//   fetch_pc<=flush_target; from WAIT without same-cycle response -> DISCARD;
//   from WAIT with same-cycle response, IDLE or DISCARD -> response dropped;
//   DISCARD stays DISCARD until response; otherwise -> IDLE.
//   In DISCARD, i_address holds old address, not flush_target (address
//   register updated but request not re-issued until IDLE).
//   -> separate req_addr register latched at issue.
//  Pop: inst_valid && inst_ready && !flush; head advances, delivered_count+1.
//  Push and pop same cycle: occupancy unchanged; full+pop+push legal.
//  Push never visible same cycle: pushed entry appears on outputs next cycle.
//  Queue full: never overflows by construction; halt: in-flight request completes
//   and is pushed, no further issue.
//  Pointers wrap mod DEPTH; inst/inst_pc = head entry, don't-care when empty.
// TESTING
//  1 Reset, mem returns 0x1000+addr one cycle after request, inst_ready=1 ->
//    inst_pc 0,1,2,... inst 0x1000,0x1001,... no gaps/dups; delivered_count tracks.
//  2 inst_ready=0, DEPTH=4 -> occupancy saturates at 4, i_readM=0; ready=1 ->
//    four pops pc 0..3 in order, fetch resumes at pc 4.
//  3 Flush to 0x0040 in WAIT, response 3 cycles later -> DISCARD, stale data
//    dropped, next inst_pc=0x0040, occupancy 0 cycle after flush.
//  4 Flush coincident with response and pop -> no push, no count increment,
//    queue empty, next request to flush_target.
//  5 flush_target=0xFFFE -> inst_pc 0xFFFE,0xFFFF,0x0000 (wrap).
//  6 halt=1 mid-WAIT -> pending response pushed, i_readM stays 0; reset_n low
//    mid-WAIT -> immediate IDLE, i_readM=0, occupancy 0, i_address=RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_prefetch_unit
// Purpose : Instruction-fetch front end with a DEPTH-entry prefetch queue.
//           It sits between instruction memory and decode. It decouples a
//           variable-latency memory (request held until a one-cycle valid
//           strobe) from decode stalls. It supports branch redirect (flush)
//           with stale-response discard, halt, and a delivered-instruction
//           counter.
// Ports   : clk, reset_n             - clock, asynchronous active-low reset
//           i_readM, i_address       - memory read request / address
//           i_data, i_data_valid     - memory read response
//           halt                     - stop issuing new requests
//           flush, flush_target      - redirect the fetch PC, drop queued work
//           inst_ready               - decode accepts the head entry
//           inst_valid, inst, inst_pc- head entry of the prefetch queue
//           occupancy                - number of queued entries
//           delivered_count          - pops since reset (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter int                   DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    output logic                         i_readM,
    output logic [WORD_SIZE-1:0]         i_address,
    input  logic [WORD_SIZE-1:0]         i_data,
    input  logic                         i_data_valid,
    input  logic                         halt,
    input  logic                         flush,
    input  logic [WORD_SIZE-1:0]         flush_target,
    input  logic                         inst_ready,
    output logic                         inst_valid,
    output logic [WORD_SIZE-1:0]         inst,
    output logic [WORD_SIZE-1:0]         inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [WORD_SIZE-1:0]         delivered_count
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                OCC_W   = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0]  c_depth = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WORD_SIZE-1:0]   r_fetch_pc;
    logic [WORD_SIZE-1:0]   r_req_addr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [OCC_W-1:0]       r_count;
    logic [WORD_SIZE-1:0]   r_delivered;
    logic [WORD_SIZE-1:0]   r_q_inst [DEPTH];
    logic [WORD_SIZE-1:0]   r_q_pc   [DEPTH];

    logic                   w_pop;
    logic                   w_push;
    logic [OCC_W-1:0]       w_occ_next;
    logic                   w_issue_ok;

    // A new request is only issued when the queue will still have a free
    // slot after this cycle's push/pop; that slot is reserved for the
    // response, so the queue can never overflow.
    always_comb begin
        w_pop      = (r_count != '0) && inst_ready && !flush;
        w_push     = (r_state == S_WAIT) && i_data_valid && !flush;
        w_occ_next = r_count + OCC_W'(w_push) - OCC_W'(w_pop);
        w_issue_ok = !halt && (w_occ_next < c_depth);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_delivered <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= flush_target;
            // An outstanding request whose response has not yet arrived must
            // be drained; r_req_addr keeps the old address so the memory sees
            // a stable request until it answers.
            if ((r_state == S_WAIT || r_state == S_DISCARD) && !i_data_valid) begin
                r_state <= S_DISCARD;
            end else begin
                r_state <= S_IDLE;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
                r_delivered <= r_delivered + WORD_SIZE'(1);
            end
            r_count <= w_occ_next;

            case (r_state)
                S_IDLE: begin
                    if (w_issue_ok) begin
                        r_state    <= S_WAIT;
                        r_req_addr <= r_fetch_pc;
                    end
                end
                S_WAIT: begin
                    if (i_data_valid) begin
                        r_fetch_pc <= r_fetch_pc + WORD_SIZE'(1);
                        if (w_issue_ok) begin
                            // Back-to-back: next address presented next cycle.
                            r_req_addr <= r_fetch_pc + WORD_SIZE'(1);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DISCARD: begin
                    if (i_data_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only observable while valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_wr_ptr] <= i_data;
            r_q_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign i_readM         = (r_state != S_IDLE);
    assign i_address       = r_req_addr;
    assign inst_valid      = (r_count != '0);
    assign inst            = inst_valid ? r_q_inst[r_rd_ptr] : '0;
    assign inst_pc         = inst_valid ? r_q_pc[r_rd_ptr] : '0;
    assign occupancy       = r_count;
    assign delivered_count = r_delivered;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_prefetch_unit
// Purpose : Self-checking bench for fetch_prefetch_unit. A memory model
//           answers each request with 0x1000+address after a programmable
//           latency; directed stimulus pushes the expected {pc, inst}
//           sequence into a scoreboard queue and a monitor compares every
//           delivered instruction against it.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;

    localparam int WS = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_readM;
    logic [WS-1:0] i_address;
    logic [WS-1:0] i_data;
    logic          i_data_valid;
    logic          halt;
    logic          flush;
    logic [WS-1:0] flush_target;
    logic          inst_ready;
    logic          inst_valid;
    logic [WS-1:0] inst;
    logic [WS-1:0] inst_pc;
    logic [2:0]    occupancy;
    logic [WS-1:0] delivered_count;

    fetch_prefetch_unit #(.WORD_SIZE(WS), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_readM        (i_readM),
        .i_address      (i_address),
        .i_data         (i_data),
        .i_data_valid   (i_data_valid),
        .halt           (halt),
        .flush          (flush),
        .flush_target   (flush_target),
        .inst_ready     (inst_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .occupancy      (occupancy),
        .delivered_count(delivered_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WS-1:0] pc;
        logic [WS-1:0] ins;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            pops_seen = 0;
    int            mem_lat = 0;
    bit            pending = 1'b0;
    int            mem_wait = 0;
    logic [WS-1:0] mem_addr = '0;

    // Memory model and delivery monitor. Memory acts on the falling edge;
    // the monitor samples 3 time units later, after stimulus has settled,
    // and judges the pop that the next rising edge will perform.
    initial begin
        exp_t e;
        i_data_valid = 1'b0;
        i_data       = '0;
        forever begin
            @(negedge clk);
            i_data_valid = 1'b0;
            if (!reset_n) begin
                pending = 1'b0;
            end else begin
                if (!pending && i_readM) begin
                    pending  = 1'b1;
                    mem_addr = i_address;
                    mem_wait = mem_lat;
                end else if (pending) begin
                    checks++;
                    if (!i_readM || i_address !== mem_addr) begin
                        errors++;
                        $display("FAIL req_hold: readM=%0b addr=%h required readM=1 addr=%h",
                                 i_readM, i_address, mem_addr);
                    end
                end
                if (pending) begin
                    if (mem_wait == 0) begin
                        i_data_valid = 1'b1;
                        i_data       = mem_addr + 16'h1000;
                        pending      = 1'b0;
                    end else begin
                        mem_wait--;
                    end
                end
            end
            #3;
            if (reset_n && inst_valid && inst_ready && !flush) begin
                pops_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: pc=%h inst=%h required no delivery", inst_pc, inst);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_pc !== e.pc || inst !== e.ins) begin
                        errors++;
                        $display("FAIL pop_data: pc=%h inst=%h required pc=%h inst=%h",
                                 inst_pc, inst, e.pc, e.ins);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [WS-1:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc  = start + WS'(i);
            e.ins = e.pc + 16'h1000;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_pops(input int n, input int budget);
        int target;
        target = pops_seen + n;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pops_seen >= target) break;
        end
        if (pops_seen < target) begin
            checks++;
            errors++;
            $display("FAIL pop_timeout: got %0d pops required %0d", pops_seen, target);
        end
    endtask

    task automatic wait_req(input logic [WS-1:0] addr, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i_readM && i_address == addr) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: addr=%h readM=%0b required request to %h", i_address, i_readM, addr);
        end
    endtask

    initial begin
        logic [WS-1:0] dc_before;
        bit            found;
        reset_n      = 1'b1;
        halt         = 1'b0;
        flush        = 1'b0;
        flush_target = '0;
        inst_ready   = 1'b0;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        check("rst_readM", 32'(i_readM), 32'd0);
        check("rst_address", 32'(i_address), 32'h0000);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_delivered", 32'(delivered_count), 32'd0);
        check("rst_inst", 32'(inst), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Streaming fetch with decode always ready
        push_exp(16'h0000, 10);
        inst_ready = 1'b1;
        run_pops(10, 100);
        inst_ready = 1'b0;
        @(negedge clk);
        check("t1_delivered", 32'(delivered_count), 32'd10);

        // Decode stalled: queue saturates, no further requests
        repeat (20) @(negedge clk);
        check("t2_occ_full", 32'(occupancy), 32'd4);
        check("t2_readM_off", 32'(i_readM), 32'd0);
        check("t2_head_pc", 32'(inst_pc), 32'h000A);
        push_exp(16'h000A, 8);
        inst_ready = 1'b1;
        run_pops(8, 100);
        inst_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("t2_refill", 32'(occupancy), 32'd4);

        // Flush while idle with a full queue, then flush during WAIT
        mem_lat      = 3;
        flush        = 1'b1;
        flush_target = 16'h0200;
        @(negedge clk);
        flush = 1'b0;
        check("t3_occ_cleared", 32'(occupancy), 32'd0);
        check("t3_valid_cleared", 32'(inst_valid), 32'd0);
        wait_req(16'h0200, 20);
        flush        = 1'b1;
        flush_target = 16'h0040;
        @(negedge clk);
        flush = 1'b0;
        check("t3_discard_readM", 32'(i_readM), 32'd1);
        check("t3_discard_addr", 32'(i_address), 32'h0200);
        check("t3_discard_occ", 32'(occupancy), 32'd0);
        push_exp(16'h0040, 3);
        inst_ready = 1'b1;
        run_pops(3, 200);
        inst_ready = 1'b0;

        // Flush coincident with a response and an attempted pop
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (i_data_valid && i_readM && occupancy != 3'd0) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_setup_found", 32'(found), 32'd1);
        dc_before    = delivered_count;
        flush        = 1'b1;
        flush_target = 16'h0300;
        inst_ready   = 1'b1;
        @(negedge clk);
        flush      = 1'b0;
        inst_ready = 1'b0;
        check("t4_occ", 32'(occupancy), 32'd0);
        check("t4_valid", 32'(inst_valid), 32'd0);
        check("t4_delivered", 32'(delivered_count), 32'(dc_before));
        check("t4_idle", 32'(i_readM), 32'd0);
        wait_req(16'h0300, 20);
        push_exp(16'h0300, 2);
        inst_ready = 1'b1;
        run_pops(2, 200);
        inst_ready = 1'b0;

        // PC wrap-around
        mem_lat      = 1;
        flush        = 1'b1;
        flush_target = 16'hFFFE;
        @(negedge clk);
        flush = 1'b0;
        push_exp(16'hFFFE, 4);
        inst_ready = 1'b1;
        run_pops(4, 200);
        inst_ready = 1'b0;

        // Halt while a request is outstanding
        mem_lat      = 3;
        flush        = 1'b1;
        flush_target = 16'h0500;
        @(negedge clk);
        flush = 1'b0;
        wait_req(16'h0500, 40);
        halt = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_halt_occ", 32'(occupancy), 32'd1);
        check("t6_halt_readM", 32'(i_readM), 32'd0);
        check("t6_halt_pc", 32'(inst_pc), 32'h0500);
        push_exp(16'h0500, 1);
        inst_ready = 1'b1;
        run_pops(1, 50);
        inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_halt_still_off", 32'(i_readM), 32'd0);
        check("t6_halt_empty", 32'(occupancy), 32'd0);
        check("t6_delivered", 32'(delivered_count), 32'(pops_seen));

        // Asynchronous reset in the middle of a WAIT
        halt = 1'b0;
        wait_req(16'h0501, 20);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_readM", 32'(i_readM), 32'd0);
        check("t6_rst_occ", 32'(occupancy), 32'd0);
        check("t6_rst_addr", 32'(i_address), 32'h0000);
        check("t6_rst_delivered", 32'(delivered_count), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push_exp(16'h0000, 2);
        inst_ready = 1'b1;
        run_pops(2, 100);
        inst_ready = 1'b0;
        @(negedge clk);
        check("t6_post_rst_delivered", 32'(delivered_count), 32'd2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
